// File: rtl/capture_readout_pkg.sv
// rtl/capture_readout_pkg.sv - shared logic-capture types and defaults
// Readout FSM state encoding and default buffer geometry.
package capture_readout_pkg;

  localparam int SAMPLE_W_DEFAULT = 16;
  localparam int ADDR_W_DEFAULT   = 10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_PRESENT   = 3'd3,
    ST_FINISH    = 3'd4
  } readout_state_t;

endpackage

// File: rtl/capture_readout.sv
// rtl/capture_readout.sv - drains a completed circular capture buffer to the host
// One read in flight at a time: FETCH -> WAIT_DATA -> PRESENT per sample.
module capture_readout
  import capture_readout_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEFAULT,
  parameter int ADDR_W   = ADDR_W_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   stop_ptr,
  input  logic [ADDR_W:0]     sample_count,
  output logic                ram_rd_en,
  output logic [ADDR_W-1:0]   ram_rd_addr,
  input  logic [SAMPLE_W-1:0] ram_rd_data,
  output logic [SAMPLE_W-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                idle,
  output logic                busy,
  output logic                done
);

  readout_state_t      state;
  logic [ADDR_W:0]     remaining;
  logic [ADDR_W-1:0]   first_addr;
  logic                count_zero;
  logic                last_sample;

  // Oldest sample sits sample_count entries behind the stop pointer, modulo DEPTH.
  assign first_addr  = stop_ptr - sample_count[ADDR_W-1:0];
  assign count_zero  = (sample_count == '0);
  assign last_sample = (remaining == (ADDR_W+1)'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      idle        <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      out_valid   <= 1'b0;
      ram_rd_en   <= 1'b0;
      ram_rd_addr <= '0;
      out_data    <= '0;
      remaining   <= '0;
    end else begin
      done      <= 1'b0;
      ram_rd_en <= 1'b0;
      if (abort && (state != ST_IDLE)) begin
        state     <= ST_IDLE;
        idle      <= 1'b1;
        busy      <= 1'b0;
        out_valid <= 1'b0;
        remaining <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !abort) begin
              ram_rd_addr <= first_addr;
              remaining   <= sample_count;
              idle        <= 1'b0;
              busy        <= 1'b1;
              if (count_zero) begin
                state <= ST_FINISH;
              end else begin
                state     <= ST_FETCH;
                ram_rd_en <= 1'b1;
              end
            end
          end
          ST_FETCH: begin
            state <= ST_WAIT_DATA;
          end
          ST_WAIT_DATA: begin
            out_data  <= ram_rd_data;
            out_valid <= 1'b1;
            state     <= ST_PRESENT;
          end
          ST_PRESENT: begin
            if (out_ready) begin
              out_valid   <= 1'b0;
              remaining   <= remaining - (ADDR_W+1)'(1);
              ram_rd_addr <= ram_rd_addr + ADDR_W'(1);
              if (last_sample) begin
                state <= ST_FINISH;
              end else begin
                state     <= ST_FETCH;
                ram_rd_en <= 1'b1;
              end
            end
          end
          ST_FINISH: begin
            done  <= 1'b1;
            state <= ST_IDLE;
            idle  <= 1'b1;
            busy  <= 1'b0;
          end
          default: begin
            state     <= ST_IDLE;
            idle      <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_capture_readout.sv
// tb/tb_capture_readout.sv - self-checking bench for capture_readout
// Queue-based readout model checked every cycle, plus literal expectations per scenario.
module tb_capture_readout;

  localparam int SW = 16;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] stop_ptr = '0;
  logic [AW:0]   sample_count = '0;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [SW-1:0] ram_rd_data = '0;
  logic [SW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          idle;
  logic          busy;
  logic          done;

  capture_readout #(.SAMPLE_W(SW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .stop_ptr(stop_ptr), .sample_count(sample_count),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .idle(idle), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [SW-1:0] ram [DEPTH];
  always @(posedge clk) if (ram_rd_en) ram_rd_data <= ram[ram_rd_addr];

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state and logs
  int            exp_addr[$];
  logic [SW-1:0] exp_data[$];
  int            addr_log[$];
  logic [SW-1:0] data_log[$];
  bit            active = 0;
  int            timer = -1;
  int            outstanding = 0;
  int            since_rd = 100;
  bit            stall_hold = 0;
  logic [SW-1:0] held = '0;
  int            n_rd = 0, n_xfer = 0, n_done = 0;

  always @(negedge clk) begin
    if (reset) begin
      exp_addr.delete(); exp_data.delete();
      active = 0; timer = -1; outstanding = 0; since_rd = 100; stall_hold = 0;
    end else begin
      if (timer >= 0) timer--;
      if (timer == 0) active = 0;
      check("done", done, timer == 0);
      check("busy", busy, active);
      check("idle", idle, !active);
      if (done) n_done++;
      if (!active) begin
        check("out_valid_inactive", out_valid, 0);
        check("rd_en_inactive", ram_rd_en, 0);
      end
      if (stall_hold) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, held);
      end
      stall_hold = active && out_valid && !out_ready && !abort;
      held = out_data;

      since_rd++;
      if (ram_rd_en) begin
        n_rd++;
        addr_log.push_back(int'(ram_rd_addr));
        check("rd_spacing", since_rd >= 3, 1);
        check("rd_outstanding", outstanding, 0);
        since_rd = 0;
        outstanding++;
        check("rd_expected", exp_addr.size() != 0, 1);
        if (exp_addr.size() != 0) check("rd_addr", ram_rd_addr, exp_addr.pop_front());
      end

      if (out_valid && out_ready) begin
        n_xfer++;
        data_log.push_back(out_data);
        outstanding--;
        check("xfer_expected", exp_data.size() != 0, 1);
        if (exp_data.size() != 0) begin
          check("out_data", out_data, exp_data.pop_front());
          if (exp_data.size() == 0) timer = 2;
        end
      end

      if (abort && active) begin
        active = 0; timer = -1; outstanding = 0;
        exp_addr.delete(); exp_data.delete();
      end else if (start && !abort && !active) begin
        active = 1;
        for (int i = 0; i < int'(sample_count); i++) begin
          int a;
          a = (((int'(stop_ptr) - int'(sample_count) + i) % DEPTH) + DEPTH) % DEPTH;
          exp_addr.push_back(a);
          exp_data.push_back(ram[a]);
        end
        if (sample_count == 0) timer = 2;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    addr_log.delete(); data_log.delete();
    n_rd = 0; n_xfer = 0; n_done = 0;
  endtask

  task automatic pulse_start(input int sp, input int cnt);
    stop_ptr = AW'(sp);
    sample_count = (AW+1)'(cnt);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (n_done == 0 && c < budget) begin
      tick();
      c++;
    end
    check("done_timeout", n_done > 0, 1);
    repeat (3) tick();
  endtask

  task automatic fill_ram(input logic [SW-1:0] base, input logic [SW-1:0] step);
    for (int i = 0; i < DEPTH; i++) ram[i] = base + SW'(i) * step;
  endtask

  int t1_addrs[16] = '{5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 0, 1, 2, 3, 4};
  int t2_addrs[6]  = '{13, 14, 15, 0, 1, 2};

  initial begin
    fill_ram(16'h1000, 16'h0101);
    repeat (3) tick();
    check("rst_idle", idle, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_rd_en", ram_rd_en, 0);
    check("rst_rd_addr", ram_rd_addr, 0);
    check("rst_out_data", out_data, 0);
    reset = 1'b0;
    tick();

    // Full buffer, wraps from stop_ptr round to stop_ptr-1
    clear_logs();
    out_ready = 1'b1;
    pulse_start(5, 16);
    wait_done(200);
    check("t1_n_xfer", n_xfer, 16);
    check("t1_n_done", n_done, 1);
    check("t1_n_addr", addr_log.size(), 16);
    if (addr_log.size() == 16)
      for (int i = 0; i < 16; i++) check("t1_addr", addr_log[i], t1_addrs[i]);

    // Partial buffer with wrap below zero
    clear_logs();
    pulse_start(3, 6);
    wait_done(100);
    check("t2_n_addr", addr_log.size(), 6);
    if (addr_log.size() == 6)
      for (int i = 0; i < 6; i++) check("t2_addr", addr_log[i], t2_addrs[i]);
    check("t2_n_data", data_log.size(), 6);
    if (data_log.size() == 6) begin
      check("t2_data0", data_log[0], 16'h1D0D);
      check("t2_data5", data_log[5], 16'h1202);
    end

    // Empty capture: no reads, done two cycles after start
    clear_logs();
    pulse_start(7, 0);
    check("t3_c1_done", done, 0);
    check("t3_c1_busy", busy, 1);
    tick();
    check("t3_c2_done", done, 1);
    check("t3_c2_idle", idle, 1);
    tick();
    check("t3_c3_done", done, 0);
    repeat (3) tick();
    check("t3_n_rd", n_rd, 0);
    check("t3_n_done", n_done, 1);

    // Host stall in PRESENT
    clear_logs();
    out_ready = 1'b0;
    pulse_start(0, 2);
    begin
      int c = 0;
      while (!out_valid && c < 20) begin tick(); c++; end
    end
    check("t4_valid_seen", out_valid, 1);
    repeat (10) tick();
    check("t4_n_rd", n_rd, 1);
    check("t4_valid_held", out_valid, 1);
    check("t4_data_held", out_data, 16'h1E0E);
    out_ready = 1'b1;
    wait_done(50);
    check("t4_n_xfer", n_xfer, 2);

    // Abort during WAIT_DATA of sample 3 of 8
    clear_logs();
    pulse_start(8, 8);
    begin
      int c = 0;
      while (!(ram_rd_en && n_rd == 2) && c < 50) begin tick(); c++; end
    end
    check("t5_third_fetch", ram_rd_en, 1);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_idle", idle, 1);
    check("t5_busy", busy, 0);
    check("t5_out_valid", out_valid, 0);
    repeat (5) tick();
    check("t5_n_done", n_done, 0);
    check("t5_n_xfer", n_xfer, 2);
    if (data_log.size() == 2) begin
      check("t5_data0", data_log[0], 16'h1000);
      check("t5_data1", data_log[1], 16'h1101);
    end
    clear_logs();
    fill_ram(16'hB000, 16'h0001);
    pulse_start(4, 3);
    wait_done(50);
    check("t5_fresh_n_xfer", n_xfer, 3);
    if (data_log.size() == 3) begin
      check("t5_fresh_data0", data_log[0], 16'hB001);
      check("t5_fresh_data2", data_log[2], 16'hB003);
    end

    // Start while busy is ignored
    clear_logs();
    pulse_start(10, 4);
    repeat (3) tick();
    pulse_start(0, 16);
    wait_done(100);
    check("t6_n_rd", n_rd, 4);
    check("t6_n_done", n_done, 1);
    if (addr_log.size() == 4) begin
      check("t6_addr0", addr_log[0], 6);
      check("t6_addr3", addr_log[3], 9);
    end

    // Start together with abort in IDLE is ignored
    clear_logs();
    stop_ptr = 4'd0;
    sample_count = 5'd5;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("t7_idle", idle, 1);
    check("t7_rd_en", ram_rd_en, 0);
    repeat (5) tick();
    check("t7_n_rd", n_rd, 0);
    check("t7_n_done", n_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1);
  end

endmodule

// File: doc/capture_readout.md
CAPTURE_READOUT -- requirements
Module: capture_readout

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16, meaning sample width in bits.
REQ-002 SHALL have parameter ADDR_W, default 10, meaning sample-buffer address width (DEPTH = 2**ADDR_W).
REQ-003 SHALL have port clk  input  1  the single clock; all logic on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin readout of a completed capture.
REQ-006 SHALL have port abort  input  1  cancel readout.
REQ-007 SHALL have port stop_ptr  input  ADDR_W  buffer write pointer at capture completion (next address that would have been written).
REQ-008 SHALL have port sample_count  input  ADDR_W+1  number of valid samples in buffer, 0..DEPTH.
REQ-009 SHALL have port ram_rd_en  output  1  buffer read strobe.
REQ-010 SHALL have port ram_rd_addr  output  ADDR_W  buffer read address.
REQ-011 SHALL have port ram_rd_data  input  SAMPLE_W  buffer data, valid the cycle after ram_rd_en.
REQ-012 SHALL have port out_data  output  SAMPLE_W  sample to host.
REQ-013 SHALL have port out_valid  output  1  out_data valid.
REQ-014 SHALL have port out_ready  input  1  host accepts; transfer when out_valid & out_ready.
REQ-015 SHALL have port idle  output  1  no readout active.
REQ-016 SHALL have port busy  output  1  readout in progress.
REQ-017 SHALL have port done  output  1  one-cycle pulse after final transfer.

Function
REQ-018 SHALL implement states IDLE, FETCH, WAIT_DATA, PRESENT, FINISH.
REQ-019 SHALL in IDLE, on start & ~abort, latch first address = (stop_ptr - sample_count) mod DEPTH and remaining = sample_count.
REQ-020 SHALL, if latched sample_count is 0, go IDLE -> FINISH directly, issuing no reads.
REQ-021 SHALL in FETCH assert ram_rd_en for exactly one cycle with ram_rd_addr = current address, then enter WAIT_DATA.
REQ-022 SHALL in WAIT_DATA capture ram_rd_data into the output register at the cycle end and enter PRESENT.
REQ-023 SHALL in PRESENT hold out_valid=1 and out_data stable until out_ready; on transfer decrement remaining, increment address modulo DEPTH (DEPTH-1 wraps to 0).
REQ-024 SHALL after a transfer go to FETCH if remaining becomes nonzero, else to FINISH.
REQ-025 SHALL in FINISH assert done for one cycle, then return to IDLE.
REQ-026 SHALL sustain at most one sample per three cycles; never more than one read outstanding.
REQ-027 SHALL ignore start when not in IDLE.
REQ-028 SHALL on abort in any non-IDLE state go to IDLE next cycle: out_valid=0, done not asserted, in-flight read data discarded.
REQ-029 SHALL give abort priority over start and over a same-cycle transfer (transfer still counts on the host side; no further samples).
REQ-030 SHALL drive idle=1 only in IDLE and busy=1 in every other state (including FINISH).
REQ-031 SHALL handle sample_count = DEPTH by starting at stop_ptr and emitting DEPTH samples.

Reset
REQ-032 SHALL on reset enter IDLE: idle=1, busy=0, done=0, out_valid=0, ram_rd_en=0, ram_rd_addr=0, out_data=0, remaining=0.
REQ-033 SHALL let reset mid-readout override all inputs, identical to REQ-032, with no done pulse.

Structure
REQ-034 SHALL place state encodings and SAMPLE_W/ADDR_W defaults in the shared logic-capture package used by the capture control FSM.
REQ-035 SHALL be a single module; no sub-module (address/count datapath is inline).

Verification
REQ-036 SHALL cover: ADDR_W=4, stop_ptr=5, sample_count=16, ready=1 -> addresses 5..15,0..4, 16 transfers, one done.
REQ-037 SHALL cover: stop_ptr=3, sample_count=6 -> addresses 13,14,15,0,1,2 (wrap), out_data matches RAM model.
REQ-038 SHALL cover: sample_count=0 start -> no ram_rd_en, done exactly 2 cycles after start, then idle.
REQ-039 SHALL cover: out_ready low 10 cycles in PRESENT -> out_data/out_valid stable, no extra ram_rd_en.
REQ-040 SHALL cover: abort during WAIT_DATA of sample 3 of 8 -> idle next cycle, out_valid=0, no done; subsequent start reads fresh.
REQ-041 SHALL cover: start while busy, and start+abort in IDLE -> both ignored, state/outputs unchanged.
